// File: rtl/systolic_feeder_if.sv
// Load port and array-side lanes of the systolic feeder.
// perf_stall_cnt exists only when SYSTOLIC_FEEDER_PERF_EN is defined.
interface systolic_feeder_if #(
  parameter int N  = 4,
  parameter int DW = 8
);
  logic                   load_valid;
  logic                   load_ready;
  logic                   load_sel;
  logic [$clog2(N)-1:0]   load_row;
  logic [N-1:0][DW-1:0]   load_data;
  logic                   go;
  logic                   stall;
  logic [N-1:0][DW-1:0]   x_in;
  logic [N-1:0][DW-1:0]   w_in;
  logic                   start;
  logic                   busy;
  logic                   tile_done;
`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [15:0]            perf_stall_cnt;

  modport slave (
    input  load_valid, load_sel, load_row, load_data, go, stall,
    output load_ready, x_in, w_in, start, busy, tile_done, perf_stall_cnt
  );
  modport master (
    output load_valid, load_sel, load_row, load_data, go, stall,
    input  load_ready, x_in, w_in, start, busy, tile_done, perf_stall_cnt
  );
`else
  modport slave (
    input  load_valid, load_sel, load_row, load_data, go, stall,
    output load_ready, x_in, w_in, start, busy, tile_done
  );
  modport master (
    output load_valid, load_sel, load_row, load_data, go, stall,
    input  load_ready, x_in, w_in, start, busy, tile_done
  );
`endif
endinterface

// File: rtl/systolic_feeder.sv
// Captures an NxN X and W tile row by row, then streams them as a diagonal wavefront
// (2 cycles go->start, 2N-1 steps, frozen by stall). Optional SYSTOLIC_FEEDER_PERF_EN.
module systolic_feeder #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input logic              clk,
  input logic              n_rst,
  systolic_feeder_if.slave bus
);
  localparam int CNT_W = $clog2(2 * N);
  localparam int IW    = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(2 * N - 2);

  typedef logic [DW-1:0] word_t;
  typedef enum logic [2:0] {IDLE, LOAD, PRIME, STREAM, DONE} state_t;

  state_t                  state_q;
  word_t [N-1:0][N-1:0]    x_mem_q;
  word_t [N-1:0][N-1:0]    w_mem_q;
  logic [N-1:0]            x_vld_q;
  logic [N-1:0]            w_vld_q;
  logic [CNT_W-1:0]        step_q;
  word_t [N-1:0]           x_in_q;
  word_t [N-1:0]           w_in_q;
  logic                    load_ready_q;
  logic                    start_q;
  logic                    busy_q;
  logic                    tile_done_q;
`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [15:0]             perf_q;
`endif

  logic                    load_fire;
  logic                    tiles_full;
  logic [CNT_W-1:0]        step_d;
  word_t [N-1:0]           x_wave_d;
  word_t [N-1:0]           w_wave_d;

  assign load_fire  = bus.load_valid && load_ready_q;
  assign tiles_full = (&x_vld_q) && (&w_vld_q);
  assign step_d     = (state_q == PRIME) ? '0 : step_q + CNT_W'(1);

  // Lane i of X carries row i delayed by i steps; lane j of W carries column j likewise.
  always_comb begin
    int d;
    logic [IW-1:0] idx;
    d        = 0;
    idx      = '0;
    x_wave_d = '0;
    w_wave_d = '0;
    for (int i = 0; i < N; i++) begin
      d   = int'(step_d) - i;
      idx = d[IW-1:0];
      if (d >= 0 && d < N) begin
        x_wave_d[i] = x_mem_q[i][idx];
        w_wave_d[i] = w_mem_q[idx][i];
      end
    end
  end

  // Tile storage deliberately survives reset.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      if (bus.load_sel) w_mem_q[bus.load_row] <= bus.load_data;
      else              x_mem_q[bus.load_row] <= bus.load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      x_vld_q      <= '0;
      w_vld_q      <= '0;
      step_q       <= '0;
      x_in_q       <= '0;
      w_in_q       <= '0;
      load_ready_q <= 1'b1;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      tile_done_q  <= 1'b0;
`ifdef SYSTOLIC_FEEDER_PERF_EN
      perf_q       <= '0;
`endif
    end else begin
      start_q     <= 1'b0;
      tile_done_q <= 1'b0;
      if (load_fire) begin
        if (bus.load_sel) w_vld_q[bus.load_row] <= 1'b1;
        else              x_vld_q[bus.load_row] <= 1'b1;
      end
`ifdef SYSTOLIC_FEEDER_PERF_EN
      if (state_q == STREAM && bus.stall && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
`endif
      case (state_q)
        IDLE: begin
          if (load_fire) state_q <= LOAD;
        end
        LOAD: begin
          // Completeness uses the bitmaps before this cycle's write.
          if (bus.go && tiles_full) begin
            state_q      <= PRIME;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b1;
`ifdef SYSTOLIC_FEEDER_PERF_EN
            perf_q       <= '0;
`endif
          end
        end
        PRIME: begin
          state_q <= STREAM;
          step_q  <= step_d;
          x_in_q  <= x_wave_d;
          w_in_q  <= w_wave_d;
          start_q <= 1'b1;
        end
        STREAM: begin
          if (!bus.stall) begin
            if (step_q == LAST_STEP) begin
              state_q     <= DONE;
              step_q      <= '0;
              x_in_q      <= '0;
              w_in_q      <= '0;
              busy_q      <= 1'b0;
              tile_done_q <= 1'b1;
            end else begin
              step_q <= step_d;
              x_in_q <= x_wave_d;
              w_in_q <= w_wave_d;
            end
          end
        end
        DONE: begin
          state_q      <= IDLE;
          x_vld_q      <= '0;
          w_vld_q      <= '0;
          load_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.x_in       = x_in_q;
  assign bus.w_in       = w_in_q;
  assign bus.start      = start_q;
  assign bus.busy       = busy_q;
  assign bus.tile_done  = tile_done_q;
`ifdef SYSTOLIC_FEEDER_PERF_EN
  assign bus.perf_stall_cnt = perf_q;
`endif
endmodule
